// File: rtl/square_motion_ctrl_pkg.sv
// Shared constants and FSM encoding for the bouncing-square motion controller,
// also used by the VGA timing generator and the render stage.
package square_motion_ctrl_pkg;

    localparam int unsigned H_RES = 640;
    localparam int unsigned V_RES = 480;
    localparam int unsigned SIZE  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        UPDATE_X = 2'd2,
        UPDATE_Y = 2'd3
    } state_e;

endpackage

// File: rtl/square_motion_ctrl_axis_bounce.sv
// One axis of square motion: position/direction register with clamp-and-bounce
// at both screen edges. Direction 1 = increasing coordinate.
module axis_bounce #(
    parameter int unsigned EXTENT = 640,
    parameter int unsigned SIZE   = 32
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       update_i,
    input  logic [2:0] step_i,
    output logic [9:0] pos_o
);

    logic [9:0]  pos_q, pos_d;
    logic        dir_q, dir_d;
    logic [10:0] pos_w, step_w, far_edge_w;

    // 11-bit arithmetic so far_edge cannot wrap near the right/bottom edge
    assign pos_w      = {1'b0, pos_q};
    assign step_w     = {8'd0, step_i};
    assign far_edge_w = pos_w + 11'(SIZE) + step_w;

    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (update_i) begin
            if (dir_q) begin
                if (far_edge_w >= 11'(EXTENT)) begin
                    pos_d = 10'(EXTENT - SIZE);
                    dir_d = 1'b0;
                end else begin
                    pos_d = pos_q + 10'(step_i);
                end
            end else begin
                if (pos_w <= step_w) begin
                    pos_d = '0;
                    dir_d = 1'b1;
                end else begin
                    pos_d = pos_q - 10'(step_i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            pos_q <= 10'((EXTENT - SIZE) / 2);
            dir_q <= 1'b1;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/square_motion_ctrl.sv
// Bouncing-square sequencer: once-per-frame position update in vertical blank,
// plus the registered square_on hit flag for the render stage.
module square_motion_ctrl
    import square_motion_ctrl_pkg::*;
#(
    parameter int unsigned H_RES_P = H_RES,
    parameter int unsigned V_RES_P = V_RES,
    parameter int unsigned SIZE_P  = SIZE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw,
    input  logic [2:0] speed,
    input  logic       frame_tick,
    input  logic       indisplayinterval,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic       square_on,
    output logic [9:0] sq_x,
    output logic [9:0] sq_y,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic       square_on_q, square_on_d;
    logic       run_w, upd_x, upd_y, load_step;

    assign run_w = sw && (speed != 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            square_on_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            square_on_q <= square_on_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (run_w) state_d = WAIT;
            WAIT: begin
                if (!run_w)                                state_d = IDLE;
                else if (frame_tick && !indisplayinterval) state_d = UPDATE_X;
            end
            UPDATE_X: state_d = UPDATE_Y;
            UPDATE_Y: state_d = run_w ? WAIT : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        upd_x     = (state_q == UPDATE_X);
        upd_y     = (state_q == UPDATE_Y);
        busy      = upd_x || upd_y;
        load_step = (state_q == WAIT) && (state_d == UPDATE_X);
        step_d    = load_step ? speed : step_q;
    end

    axis_bounce #(.EXTENT(H_RES_P), .SIZE(SIZE_P)) u_axis_x (
        .clk      (clk),
        .rst_i    (reset),
        .update_i (upd_x),
        .step_i   (step_q),
        .pos_o    (sq_x)
    );

    axis_bounce #(.EXTENT(V_RES_P), .SIZE(SIZE_P)) u_axis_y (
        .clk      (clk),
        .rst_i    (reset),
        .update_i (upd_y),
        .step_i   (step_q),
        .pos_o    (sq_y)
    );

    always_comb begin
        square_on_d = indisplayinterval
                   && ({1'b0, pixel_x} >= {1'b0, sq_x})
                   && ({1'b0, pixel_x} <  {1'b0, sq_x} + 11'(SIZE_P))
                   && ({1'b0, pixel_y} >= {1'b0, sq_y})
                   && ({1'b0, pixel_y} <  {1'b0, sq_y} + 11'(SIZE_P));
    end

    assign square_on = square_on_q;

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Directed bench for square_motion_ctrl with hand-computed expected positions.
module tb_square_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sw = 1'b0;
    logic [2:0] speed = 3'd0;
    logic       frame_tick = 1'b0;
    logic       indisplayinterval = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic       square_on;
    logic [9:0] sq_x, sq_y;
    logic       busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    square_motion_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .sw                (sw),
        .speed             (speed),
        .frame_tick        (frame_tick),
        .indisplayinterval (indisplayinterval),
        .pixel_x           (pixel_x),
        .pixel_y           (pixel_y),
        .square_on         (square_on),
        .sq_x              (sq_x),
        .sq_y              (sq_y),
        .busy              (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change on negedge; outputs sampled on negedge, half a cycle after the active edge.
    task automatic tick(input logic hold_during_busy);
        @(negedge clk);
        frame_tick = 1'b1;
        indisplayinterval = 1'b0;
        @(negedge clk);
        if (!hold_during_busy) frame_tick = 1'b0;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic check_pos(input string tag, input int unsigned ex, input int unsigned ey);
        check({tag, ".x"}, 32'(sq_x), 32'(ex));
        check({tag, ".y"}, 32'(sq_y), 32'(ey));
    endtask

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       ind;
        logic       exp;
    } pix_vec_t;

    pix_vec_t pix_tab[6] = '{
        '{10'd304, 10'd224, 1'b1, 1'b1},
        '{10'd336, 10'd224, 1'b1, 1'b0},
        '{10'd335, 10'd255, 1'b1, 1'b1},
        '{10'd303, 10'd224, 1'b1, 1'b0},
        '{10'd304, 10'd256, 1'b1, 1'b0},
        '{10'd310, 10'd230, 1'b0, 1'b0}
    };

    initial begin
        repeat (2) @(negedge clk);
        check_pos("rst", 304, 224);
        check("rst.square_on", 32'(square_on), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // square_on compare at the centred reset position
        foreach (pix_tab[i]) begin
            pixel_x = pix_tab[i].px;
            pixel_y = pix_tab[i].py;
            indisplayinterval = pix_tab[i].ind;
            @(negedge clk);
            check($sformatf("square_on[%0d]", i), 32'(square_on), 32'(pix_tab[i].exp));
        end
        indisplayinterval = 1'b0;

        // dropped ticks: sw=0, speed=0, tick during visible area
        tick(1'b0);
        check_pos("sw0", 304, 224);
        sw = 1'b1;
        tick(1'b0);
        check_pos("speed0", 304, 224);
        speed = 3'd4;
        @(negedge clk);
        frame_tick = 1'b1;
        indisplayinterval = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        indisplayinterval = 1'b0;
        repeat (3) @(negedge clk);
        check_pos("visible", 304, 224);
        check("visible.busy", 32'(busy), 32'd0);

        // one update: busy for exactly two cycles
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("busy.c1", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy.c2", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy.c3", 32'(busy), 32'd0);
        check_pos("step4", 308, 228);

        // tick held high through UPDATE_X is not queued
        tick(1'b1);
        check_pos("busytick", 312, 232);

        // right/bottom bounce at speed 7
        speed = 3'd7;
        ticks(42);
        check_pos("run42", 606, 371);
        tick(1'b0);
        check_pos("xclamp", 608, 364);
        tick(1'b0);
        check_pos("xback", 601, 357);

        // approach top edge, then clamp to 0 at speed 5
        speed = 3'd4;
        tick(1'b0);
        check_pos("s4", 597, 353);
        speed = 3'd7;
        ticks(50);
        check_pos("y3", 247, 3);
        speed = 3'd5;
        tick(1'b0);
        check_pos("yclamp", 242, 0);
        tick(1'b0);
        check_pos("ybounce", 237, 5);

        // sw falls during the update: update completes, then IDLE
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        sw = 1'b0;
        repeat (3) @(negedge clk);
        check_pos("swfall", 232, 10);
        check("swfall.busy", 32'(busy), 32'd0);
        tick(1'b0);
        check_pos("idle", 232, 10);

        // async reset mid-cycle clears everything without a clock edge
        pixel_x = 10'd232;
        pixel_y = 10'd10;
        indisplayinterval = 1'b1;
        @(negedge clk);
        check("pre_rst.square_on", 32'(square_on), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_pos("arst", 304, 224);
        check("arst.square_on", 32'(square_on), 32'd0);
        check("arst.busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
